// File: rtl/debug_overlay_writer.sv
// Scans NUM_PROBES probe words and paints each as MSB-first hex glyphs into the BAM, one row per probe.
// Optional feature DEBUG_OVERLAY_DIRTY_EN: rows whose probe value is unchanged since last painted are skipped.
module debug_overlay_writer #(
  parameter int CHARS_PER_ROW = 80,
  parameter int NUM_PROBES    = 42,
  parameter int DATA_WIDTH    = 32,
  parameter int ROW_BASE      = 0,
  parameter int COL_BASE      = 13,
  parameter int ADDR_WIDTH    = 13,
  localparam int DIGITS = DATA_WIDTH / 4,
  localparam int IDX_W  = (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1,
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  force_all,
  output logic [IDX_W-1:0]      probe_sel,
  input  logic [DATA_WIDTH-1:0] probe_data,
  output logic                  bg_wrt,
  input  logic                  bg_ready,
  output logic [ADDR_WIDTH-1:0] bam_addr,
  output logic [7:0]            bam_write_data,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [2:0] {IDLE, SEL, LATCH, WRITE, NEXT} state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DIG_W-1:0]      digit_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [IDX_W-1:0]      probe_sel_q;
  logic                  bg_wrt_q;
  logic [ADDR_WIDTH-1:0] bam_addr_q;
  logic [7:0]            bam_data_q;
  logic                  busy_q;
  logic                  frame_done_q;

  logic                  row_dirty_d;
  logic [DATA_WIDTH-1:0] next_sh_d;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    return (n < 4'd10) ? (8'h10 + {4'h0, n}) : (8'h17 + {4'h0, n});
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [IDX_W-1:0] i);
    return (ADDR_WIDTH'(ROW_BASE) + ADDR_WIDTH'(i)) * ADDR_WIDTH'(CHARS_PER_ROW)
           + ADDR_WIDTH'(COL_BASE);
  endfunction

  // Top nibble of this shifted copy is the glyph source for the next digit.
  assign next_sh_d = hold_q << {digit_q + DIG_W'(1), 2'b00};

`ifdef DEBUG_OVERLAY_DIRTY_EN
  logic [DATA_WIDTH-1:0] shadow_q [NUM_PROBES];
  logic [NUM_PROBES-1:0] valid_q;

  assign row_dirty_d = force_all || !valid_q[idx_q] || (shadow_q[idx_q] != probe_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_PROBES; i++) shadow_q[i] <= '0;
    end else begin
      if (force_all) valid_q <= '0;
      // Later assignment wins, so a row repainted during force_all stays valid.
      if (state_q == LATCH && row_dirty_d) begin
        valid_q[idx_q]  <= 1'b1;
        shadow_q[idx_q] <= probe_data;
      end
    end
  end
`else
  assign row_dirty_d = 1'b1 | force_all;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      digit_q      <= '0;
      hold_q       <= '0;
      probe_sel_q  <= '0;
      bg_wrt_q     <= 1'b0;
      bam_addr_q   <= '0;
      bam_data_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            idx_q       <= '0;
            probe_sel_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= SEL;
          end
        end
        SEL: state_q <= LATCH;
        LATCH: begin
          hold_q  <= probe_data;
          digit_q <= '0;
          if (row_dirty_d) begin
            bg_wrt_q   <= 1'b1;
            bam_addr_q <= row_addr(idx_q);
            bam_data_q <= glyph(probe_data[DATA_WIDTH-1 -: 4]);
            state_q    <= WRITE;
          end else begin
            state_q <= NEXT;
          end
        end
        WRITE: begin
          if (bg_ready) begin
            if (digit_q == DIG_W'(DIGITS - 1)) begin
              bg_wrt_q <= 1'b0;
              state_q  <= NEXT;
            end else begin
              digit_q    <= digit_q + DIG_W'(1);
              bam_addr_q <= bam_addr_q + ADDR_WIDTH'(1);
              bam_data_q <= glyph(next_sh_d[DATA_WIDTH-1 -: 4]);
            end
          end
        end
        NEXT: begin
          if (idx_q == IDX_W'(NUM_PROBES - 1)) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            idx_q       <= idx_q + IDX_W'(1);
            probe_sel_q <= idx_q + IDX_W'(1);
            state_q     <= SEL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign probe_sel      = probe_sel_q;
  assign bg_wrt         = bg_wrt_q;
  assign bam_addr       = bam_addr_q;
  assign bam_write_data = bam_data_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_debug_overlay_writer.sv
// Directed bench for debug_overlay_writer: two 32-bit probes, hand-computed glyph table and frame lengths.
module tb_debug_overlay_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        force_all;
  logic [0:0]  probe_sel;
  logic [31:0] probe_data;
  logic        bg_wrt;
  logic        bg_ready;
  logic [12:0] bam_addr;
  logic [7:0]  bam_write_data;
  logic        busy;
  logic        frame_done;

  logic [31:0] probe0, probe1;
  int n_checks = 0;
  int n_fail   = 0;
  int stall_addr = -1;
  int stall_len  = 0;
  int stall_cnt  = 0;
  bit late_chg   = 1'b0;
  int hold17     = 0;
  int n;
  int busy_seen;
  logic [12:0] wa[$];
  logic [7:0]  wd[$];
  logic [7:0]  exp_glyph [16];

  debug_overlay_writer #(
    .CHARS_PER_ROW(80), .NUM_PROBES(2), .DATA_WIDTH(32),
    .ROW_BASE(0), .COL_BASE(13), .ADDR_WIDTH(13)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .force_all(force_all),
    .probe_sel(probe_sel), .probe_data(probe_data),
    .bg_wrt(bg_wrt), .bg_ready(bg_ready), .bam_addr(bam_addr),
    .bam_write_data(bam_write_data), .busy(busy), .frame_done(frame_done)
  );

  assign probe_data = probe_sel[0] ? probe1 : probe0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bg_wrt && bg_ready) begin
      wa.push_back(bam_addr);
      wd.push_back(bam_write_data);
    end
    if (rst_n && bg_wrt && bam_addr == 13'd17 && bam_write_data == 8'h10) hold17++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until frame_done (bounded); returns ticks taken since the call.
  task automatic run(input int limit, input int drop_at, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (cnt == drop_at) enable = 1'b0;
      if (late_chg && bg_wrt && bam_addr == 13'd95) probe1 = 32'h1234_5678;
      bg_ready = !(bg_wrt && (int'(bam_addr) == stall_addr) && (stall_cnt < stall_len));
      if (!bg_ready) stall_cnt++;
    end while (!frame_done && cnt < limit);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, wa.size(), 16);
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), {19'd0, wa[i]}, (i < 8) ? 13 + i : 85 + i);
      check($sformatf("%s_data%0d", tag, i), {24'd0, wd[i]}, {24'd0, exp_glyph[i]});
    end
  endtask

  initial begin
    exp_glyph = '{8'h10, 8'h10, 8'h14, 8'h10, 8'h10, 8'h10, 8'h21, 8'h23,
                  8'h24, 8'h25, 8'h21, 8'h24, 8'h22, 8'h25, 8'h25, 8'h26};
    rst_n = 1'b1; enable = 1'b0; force_all = 1'b1; bg_ready = 1'b1;
    probe0 = 32'h0040_00AC; probe1 = 32'hDEAD_BEEF;
    #1 rst_n = 1'b0;
    #1;
    check("rst_probe_sel", {31'd0, probe_sel}, 0);
    check("rst_bg_wrt", {31'd0, bg_wrt}, 0);
    check("rst_bam_addr", {19'd0, bam_addr}, 0);
    check("rst_bam_data", {24'd0, bam_write_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Basic frame, single-cycle enable pulse
    wa.delete(); enable = 1'b1;
    run(60, 1, n);
    check("basic_len", n, 23);
    check("basic_busy_at_done", {31'd0, busy}, 0);
    check_writes("basic");
    tick();
    check("basic_done_width", {31'd0, frame_done}, 0);
    check("basic_idle_busy", {31'd0, busy}, 0);

    // Back-pressure on digit 4 of probe 0
    stall_addr = 17; stall_len = 3; stall_cnt = 0; hold17 = 0;
    wa.delete(); enable = 1'b1;
    run(60, 1, n);
    stall_len = 0;
    check("bp_len", n, 26);
    check("bp_hold17", hold17, 4);
    check("bp_stalls", stall_cnt, 3);
    check_writes("bp");

    // Probe 1 changes while its row is being painted
    late_chg = 1'b1;
    wa.delete(); enable = 1'b1;
    run(60, 1, n);
    late_chg = 1'b0;
    check("late_len", n, 23);
    check_writes("late");
    probe1 = 32'hDEAD_BEEF;

    // Continuous run, then drop enable mid-frame
    enable = 1'b1;
    run(60, 0, n);
    check("cont_first", n, 23);
    run(60, 0, n);
    check("cont_period", n, 23);
    run(60, 5, n);
    check("cont_drop_len", n, 23);
    busy_seen = 0;
    repeat (6) begin
      tick();
      if (busy || bg_wrt) busy_seen++;
    end
    check("cont_stay_idle", busy_seen, 0);

    // Asynchronous reset in the middle of a WRITE
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int k = 0; k < 30 && !(bg_wrt && bam_addr == 13'd15); k++) tick();
    check("ar_reach_write", {19'd0, bam_addr}, 15);
    #2 rst_n = 1'b0;
    #1;
    check("ar_probe_sel", {31'd0, probe_sel}, 0);
    check("ar_bg_wrt", {31'd0, bg_wrt}, 0);
    check("ar_bam_addr", {19'd0, bam_addr}, 0);
    check("ar_bam_data", {24'd0, bam_write_data}, 0);
    check("ar_busy", {31'd0, busy}, 0);
    check("ar_frame_done", {31'd0, frame_done}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    busy_seen = 0;
    repeat (4) begin
      tick();
      if (busy || bg_wrt) busy_seen++;
    end
    check("ar_idle", busy_seen, 0);
    wa.delete(); enable = 1'b1;
    run(60, 1, n);
    check("ar_frame_len", n, 23);
    check_writes("ar");

`ifdef DEBUG_OVERLAY_DIRTY_EN
    force_all = 1'b0;
    wa.delete(); enable = 1'b1;
    run(60, 1, n);
    check("dirty_clean_len", n, 7);
    check("dirty_clean_writes", wa.size(), 0);
    probe1 = 32'h0000_0001;
    wa.delete(); enable = 1'b1;
    run(60, 1, n);
    check("dirty_one_len", n, 15);
    check("dirty_one_writes", wa.size(), 8);
    if (wa.size() == 8) begin
      check("dirty_one_first", {19'd0, wa[0]}, 93);
      check("dirty_one_last", {19'd0, wa[7]}, 100);
      check("dirty_one_glyph", {24'd0, wd[7]}, 32'h11);
    end
    force_all = 1'b1;
    tick();
    force_all = 1'b0;
    wa.delete(); enable = 1'b1;
    run(60, 1, n);
    check("dirty_force_len", n, 23);
    check("dirty_force_writes", wa.size(), 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
